// File: rtl/ut_sched_pkg.sv
// ut_sched_pkg: state encoding, default window size and MAC-window length helper
// shared by the ut_array_sched sequencer.
package ut_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_WLOAD,
    ST_COMP
  } ut_state_e;

  localparam int unsigned UT_FULL_WIN   = 128;
  localparam int          UT_IWIDTH_DEF = $clog2(UT_FULL_WIN) + 1;

  // L = max(1, 2^(iwidth-1) >> shift)
  function automatic int unsigned win_len(input int unsigned iwidth, input int unsigned shift);
    if (shift >= iwidth - 32'd1) return 32'd1;
    return (32'd1 << (iwidth - 32'd1)) >> shift;
  endfunction

endpackage

// File: rtl/ut_skew_line.sv
// ut_skew_line: N-tap delay line, q[k] is d delayed by k cycles (q[0] = d).
// Async active-low reset, synchronous flush.
module ut_skew_line #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         d,
  output logic [N-1:0] q
);

  logic [N-2:0] r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_dly <= '0;
    else if (flush) r_dly <= '0;
    else            r_dly <= (N-1)'({r_dly, d});
  end

  assign q = {r_dly, d};

endmodule

// File: rtl/ut_array_sched.sv
// ut_array_sched: control sequencer for a HEIGHT x WIDTH unary-temporal systolic array.
// Define UT_SCHED_EBT_EN to honour ebt_shift (early termination); otherwise L = 2^(IWIDTH-1).
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_CLR   | one cycle, clear all weight/input/output registers
// ST_WLOAD | HEIGHT cycles, shift weight rows in
// ST_COMP  | row-0 windows for every vector, then tail drain of the skew lines
module ut_array_sched
  import ut_sched_pkg::*;
#(
  parameter int HEIGHT = 32,
  parameter int WIDTH  = 32,
  parameter int IWIDTH = UT_IWIDTH_DEF,
  parameter int NVW    = 16,
  parameter int SW     = $clog2(IWIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NVW-1:0]    num_vec,
  input  logic [SW-1:0]     ebt_shift,
  output logic              busy,
  output logic              done,
  output logic              wght_req,
  output logic              ifm_req,
  output logic [WIDTH-1:0]  en_w,
  output logic [WIDTH-1:0]  clr_w,
  output logic [HEIGHT-1:0] en_i,
  output logic [HEIGHT-1:0] clr_i,
  output logic [HEIGHT-1:0] mac_done,
  output logic [WIDTH-1:0]  en_o,
  output logic [WIDTH-1:0]  clr_o
);

  localparam int WW = IWIDTH - 1;
  localparam int TW = $clog2(HEIGHT + WIDTH);

  ut_state_e        r_state, w_state_nxt;
  logic [WW-1:0]    r_win, w_win_nxt, w_lm1;
  logic [NVW-1:0]   r_vec, w_vec_nxt, r_nv;
  logic [TW-1:0]    r_tmr, w_tmr_nxt;
  logic             w_accept;
  logic             w_act_nxt, w_clr_nxt, w_wload_nxt, w_done_nxt;
  logic             w_en_i0_nxt, w_clr_i0_nxt, w_mac0_nxt;
  logic [HEIGHT-1:0] w_en_i_tap, w_clr_i_tap, w_mac_tap;
  logic [WIDTH-1:0]  w_en_o_tap, w_clr_o_tap;

  assign w_accept = (r_state == ST_IDLE) && start && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_nv <= '0;
    else if (w_accept) r_nv <= num_vec;
  end

`ifdef UT_SCHED_EBT_EN
  logic [SW-1:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_shift <= '0;
    else if (w_accept) r_shift <= ebt_shift;
  end

  assign w_lm1 = WW'(win_len(IWIDTH, 32'(r_shift)) - 32'd1);
`else
  localparam int unsigned FULL_WIN = win_len(IWIDTH, 0);
  logic w_unused_shift;

  assign w_unused_shift = ^ebt_shift;
  assign w_lm1          = WW'(FULL_WIN - 32'd1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_win   <= '0;
      r_vec   <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
      r_vec   <= w_vec_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_vec_nxt   = r_vec;
    w_tmr_nxt   = r_tmr;
    case (r_state)
      ST_IDLE: begin
        w_win_nxt = '0;
        w_vec_nxt = '0;
        if (start && num_vec != '0) w_state_nxt = ST_CLR;
      end
      ST_CLR: begin
        w_state_nxt = ST_WLOAD;
        w_tmr_nxt   = TW'(HEIGHT - 1);
      end
      ST_WLOAD: begin
        w_tmr_nxt = r_tmr - 1'b1;
        if (r_tmr == '0) w_state_nxt = ST_COMP;
      end
      ST_COMP: begin
        if (r_vec < r_nv) begin
          if (r_win == w_lm1) begin
            w_win_nxt = '0;
            w_vec_nxt = r_vec + 1'b1;
            // tail: skew lines still emit for HEIGHT+WIDTH-1 cycles after the last window
            w_tmr_nxt = TW'(HEIGHT + WIDTH - 2);
          end else begin
            w_win_nxt = r_win + 1'b1;
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
          if (r_tmr == '0) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_win_nxt   = '0;
      w_vec_nxt   = '0;
    end
  end

  // Values each output takes in the next cycle; registered below.
  always_comb begin
    w_act_nxt    = (w_state_nxt == ST_COMP) && (w_vec_nxt < r_nv);
    w_clr_nxt    = (w_state_nxt == ST_CLR);
    w_wload_nxt  = (w_state_nxt == ST_WLOAD);
    w_en_i0_nxt  = w_act_nxt;
    w_clr_i0_nxt = w_act_nxt && (w_win_nxt == '0);
    w_mac0_nxt   = w_act_nxt && (w_win_nxt == w_lm1);
    w_done_nxt   = !abort && (((r_state == ST_IDLE) && start && (num_vec == '0)) ||
                              ((r_state == ST_COMP) && (w_state_nxt == ST_IDLE)));
  end

  ut_skew_line #(.N(HEIGHT)) u_skew_en_i (
    .clk(clk), .rst_n(rst_n), .flush(abort), .d(w_en_i0_nxt), .q(w_en_i_tap));
  ut_skew_line #(.N(HEIGHT)) u_skew_clr_i (
    .clk(clk), .rst_n(rst_n), .flush(abort), .d(w_clr_i0_nxt), .q(w_clr_i_tap));
  ut_skew_line #(.N(HEIGHT)) u_skew_mac (
    .clk(clk), .rst_n(rst_n), .flush(abort), .d(w_mac0_nxt), .q(w_mac_tap));

  // Column 0 output enable follows the last row's mac_done by one cycle.
  ut_skew_line #(.N(WIDTH)) u_skew_en_o (
    .clk(clk), .rst_n(rst_n), .flush(abort), .d(mac_done[HEIGHT-1]), .q(w_en_o_tap));
  ut_skew_line #(.N(WIDTH)) u_skew_clr_o (
    .clk(clk), .rst_n(rst_n), .flush(abort), .d(en_o[0]), .q(w_clr_o_tap));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      wght_req <= 1'b0;
      ifm_req  <= 1'b0;
      en_w     <= '0;
      clr_w    <= '0;
      en_i     <= '0;
      clr_i    <= '0;
      mac_done <= '0;
      en_o     <= '0;
      clr_o    <= '0;
    end else if (abort) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      wght_req <= 1'b0;
      ifm_req  <= 1'b0;
      en_w     <= '0;
      clr_w    <= '0;
      en_i     <= '0;
      clr_i    <= '0;
      mac_done <= '0;
      en_o     <= '0;
      clr_o    <= '0;
    end else begin
      busy     <= (w_state_nxt != ST_IDLE);
      done     <= w_done_nxt;
      wght_req <= w_wload_nxt;
      ifm_req  <= w_clr_i0_nxt;
      en_w     <= {WIDTH{w_wload_nxt}};
      clr_w    <= {WIDTH{w_clr_nxt}};
      en_i     <= w_en_i_tap;
      clr_i    <= w_clr_i_tap | {HEIGHT{w_clr_nxt}};
      mac_done <= w_mac_tap;
      en_o     <= w_en_o_tap;
      clr_o    <= w_clr_o_tap | {WIDTH{w_clr_nxt}};
    end
  end

endmodule
